// File: rtl/trcd_bist_tpg.sv
// -----------------------------------------------------------------------------
// trcd_bist_tpg
//
// Self-test pattern generator and sequencer for the trcd signature block (ORA).
// During a run it takes the place of the CPU as the writer into trcd. It first
// clears the ORA for one cycle and then issues NUM_PATTERNS address/data writes.
// The write stream comes from a 32-bit Galois LFSR that uses the same feedback
// as the ORA's MISR. After the last write it samples the ORA signature and
// compares it against GOLDEN.
//
// Control protocol (test controller side):
//   start and abort are plain levels that are sampled on every rising edge.
//   A run begins when start=1 is seen in IDLE or DONE. start is ignored while
//   busy. abort=1 forces IDLE from any state and takes priority over start.
//   There is no ready/acknowledge: the controller observes busy/done/pass.
//
// Ports:
//   clk              in   clock, rising-edge
//   rst              in   asynchronous active-high reset
//   start            in   begin a run (IDLE/DONE only)
//   abort            in   return to IDLE from any state
//   ora_clr          out  high for the single LOAD cycle; ORed into trcd's rst
//   mem_access_addr  out  [15:0] write address to trcd (pattern bits 31:16)
//   mem_write_data   out  [15:0] write data to trcd   (pattern bits 15:0)
//   mem_write_en     out  write strobe, high for exactly NUM_PATTERNS cycles
//   mem_read_data    in   [31:0] ORA signature from trcd
//   busy             out  high in LOAD, RUN and CHECK
//   done             out  high in DONE
//   pass             out  valid while done=1; signature matched GOLDEN
//   signature        out  [31:0] ORA value sampled in CHECK, held until LOAD
//
// Every output is a flop with asynchronous reset. A reset in the middle of a
// run therefore drops mem_write_en at once, with no partial or glitch write.
// -----------------------------------------------------------------------------
module trcd_bist_tpg #(
  parameter logic [31:0] SEED         = 32'h0000_0001,
  parameter logic [15:0] NUM_PATTERNS = 16'd256,
  parameter logic [31:0] GOLDEN       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        ora_clr,
  output logic [15:0] mem_access_addr,
  output logic [15:0] mem_write_data,
  output logic        mem_write_en,
  input  logic [31:0] mem_read_data,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature
);

  // State encoding. state_q is a plain named signal so that checkers can bind
  // to it directly.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // The RUN exit is taken on the last pattern index, so cnt never has to hold
  // NUM_PATTERNS as the compare value and the 16-bit counter cannot wrap.
  localparam logic [15:0] LAST_IDX = NUM_PATTERNS - 16'd1;

  state_t      state_q;
  state_t      state_d;

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next values for the registered outputs.
  logic        ora_clr_d;
  logic        write_en_d;
  logic [15:0] addr_d;
  logic [15:0] data_d;
  logic        busy_d;
  logic        done_d;
  logic        pass_d;
  logic [31:0] signature_d;

  // Pattern that will be on the bus in the next cycle, when that cycle is RUN.
  logic [31:0] next_pattern;

  // Galois step with the same taps as the ORA MISR feedback.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = {s[30:22], s[31] ^ s[21], s[20:2],
                 s[31] ^ s[1], s[31] ^ s[0], s[31]};
  endfunction

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_LOAD;
        ST_LOAD:  state_d = ST_RUN;
        ST_RUN:   if (cnt_q == LAST_IDX) state_d = ST_CHECK;
        ST_CHECK: state_d = ST_DONE;
        ST_DONE:  if (start) state_d = ST_LOAD;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  //
  // The outputs are registered. Their next values therefore follow the state
  // being entered (state_d), so each output is valid throughout the cycle it
  // describes. The LFSR holds s_cnt while in RUN. Entering RUN from LOAD puts
  // s_0 = SEED on the bus. Each following RUN cycle puts f(lfsr), which is
  // s_(cnt+1), on the bus.
  // ---------------------------------------------------------------------------
  always_comb begin
    next_pattern = (state_q == ST_LOAD) ? SEED : lfsr_step(lfsr_q);

    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    ora_clr_d   = 1'b0;
    write_en_d  = 1'b0;
    addr_d      = 16'h0000;
    data_d      = 16'h0000;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    pass_d      = 1'b0;
    signature_d = signature;

    // Outputs for the cycle being entered. IDLE, including after an abort,
    // leaves everything at zero except the held signature.
    case (state_d)
      ST_LOAD: begin
        ora_clr_d = 1'b1;
        busy_d    = 1'b1;
      end
      ST_RUN: begin
        write_en_d = 1'b1;
        busy_d     = 1'b1;
        addr_d     = next_pattern[31:16];
        data_d     = next_pattern[15:0];
      end
      ST_CHECK: begin
        busy_d = 1'b1;
      end
      ST_DONE: begin
        done_d = 1'b1;
        // Compare once, on the CHECK->DONE edge, then hold.
        pass_d = (state_q == ST_CHECK) ? (mem_read_data == GOLDEN) : pass;
      end
      default: ;
    endcase

    // Work done in the current cycle.
    case (state_q)
      ST_LOAD: begin
        lfsr_d      = SEED;
        cnt_d       = 16'd0;
        signature_d = 32'h0000_0000;
      end
      ST_RUN: begin
        lfsr_d = lfsr_step(lfsr_q);
        cnt_d  = cnt_q + 16'd1;
      end
      ST_CHECK: begin
        // The ORA absorbed the last write at the end of the final RUN cycle.
        // Its value here is the run's signature. An abort in this cycle
        // discards the sample.
        if (!abort) signature_d = mem_read_data;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q          <= SEED;
      cnt_q           <= 16'd0;
      ora_clr         <= 1'b0;
      mem_write_en    <= 1'b0;
      mem_access_addr <= 16'h0000;
      mem_write_data  <= 16'h0000;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      signature       <= 32'h0000_0000;
    end else begin
      lfsr_q          <= lfsr_d;
      cnt_q           <= cnt_d;
      ora_clr         <= ora_clr_d;
      mem_write_en    <= write_en_d;
      mem_access_addr <= addr_d;
      mem_write_data  <= data_d;
      busy            <= busy_d;
      done            <= done_d;
      pass            <= pass_d;
      signature       <= signature_d;
    end
  end

endmodule

// File: tb/tb_trcd_bist_tpg.sv
// -----------------------------------------------------------------------------
// tb_trcd_bist_tpg
//
// Four generator instances with different parameters run side by side. Each
// one drives its own behavioural ORA (MISR) model, which is cleared by
// rst | ora_clr:
//   0: SEED=1,           NUM_PATTERNS=2,   GOLDEN=0
//   1: SEED=32'h80000000, NUM_PATTERNS=2,  GOLDEN=0
//   2: SEED=1,           NUM_PATTERNS=256, GOLDEN=ora_ref(1,256)
//   3: SEED=1,           NUM_PATTERNS=256, GOLDEN=ora_ref(1,256)^1
// Inputs are driven at the falling edge and outputs are sampled at the
// falling edge.
// -----------------------------------------------------------------------------
module tb_trcd_bist_tpg;

  // Next-state function of the reference LFSR/MISR.
  function automatic logic [31:0] ref_step(input logic [31:0] s);
    ref_step = {s[30:22], s[31] ^ s[21], s[20:2],
                s[31] ^ s[1], s[31] ^ s[0], s[31]};
  endfunction

  // Reference ORA signature: MISR cleared, then absorbs n patterns s_0..s_n-1.
  function automatic logic [31:0] ora_ref(input logic [31:0] seed, input int n);
    logic [31:0] m;
    logic [31:0] s;
    m = 32'h0;
    s = seed;
    for (int k = 0; k < n; k++) begin
      m = ref_step(m) ^ s;
      s = ref_step(s);
    end
    ora_ref = m;
  endfunction

  localparam logic [31:0] GOLD_C = ora_ref(32'h0000_0001, 256);

  localparam logic [3:0][31:0] SEEDS = {32'h0000_0001, 32'h0000_0001,
                                        32'h8000_0000, 32'h0000_0001};
  localparam logic [3:0][15:0] NPATS = {16'd256, 16'd256, 16'd2, 16'd2};
  localparam logic [3:0][31:0] GOLDS = {GOLD_C ^ 32'h1, GOLD_C,
                                        32'h0000_0000, 32'h0000_0000};

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_v   [4];
  logic        abort_v   [4];
  logic        ora_clr_v [4];
  logic [15:0] addr_v    [4];
  logic [15:0] data_v    [4];
  logic        we_v      [4];
  logic [31:0] rd_v      [4];
  logic        busy_v    [4];
  logic        done_v    [4];
  logic        pass_v    [4];
  logic [31:0] sig_v     [4];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    trcd_bist_tpg #(
      .SEED         (SEEDS[g]),
      .NUM_PATTERNS (NPATS[g]),
      .GOLDEN       (GOLDS[g])
    ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start_v[g]),
      .abort           (abort_v[g]),
      .ora_clr         (ora_clr_v[g]),
      .mem_access_addr (addr_v[g]),
      .mem_write_data  (data_v[g]),
      .mem_write_en    (we_v[g]),
      .mem_read_data   (rd_v[g]),
      .busy            (busy_v[g]),
      .done            (done_v[g]),
      .pass            (pass_v[g]),
      .signature       (sig_v[g])
    );

    // Behavioural ORA: MISR that absorbs {addr,data} on each write.
    logic        ora_rst;
    logic [31:0] misr;
    assign ora_rst = rst | ora_clr_v[g];
    always_ff @(posedge clk or posedge ora_rst) begin
      if (ora_rst) misr <= 32'h0;
      else if (we_v[g]) misr <= ref_step(misr) ^ {addr_v[g], data_v[g]};
    end
    assign rd_v[g] = misr;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
  endtask

  // Leaves the caller at the negedge inside the LOAD cycle.
  task automatic pulse_start(input int idx);
    start_v[idx] = 1'b1;
    tick();
    start_v[idx] = 1'b0;
  endtask

  // Advance until done, counting write cycles; bounded by budget.
  task automatic wait_done(input int idx, input int budget,
                           output int writes, output bit timed_out);
    writes    = 0;
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (done_v[idx]) begin
        timed_out = 1'b0;
        break;
      end
      if (we_v[idx]) writes++;
      tick();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    bit clr_seen;
    rst = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({ora_clr_v[i], we_v[i], busy_v[i], done_v[i], pass_v[i],
           addr_v[i], data_v[i], sig_v[i]} !== 68'h0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: clr=%b we=%b busy=%b done=%b pass=%b addr=%h data=%h sig=%h, required all 0",
                 i, ora_clr_v[i], we_v[i], busy_v[i], done_v[i], pass_v[i],
                 addr_v[i], data_v[i], sig_v[i]);
      end
    end
    rst = 1'b0;
    clr_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      for (int i = 0; i < 4; i++)
        if (ora_clr_v[i] !== 1'b0 || busy_v[i] !== 1'b0 || we_v[i] !== 1'b0)
          clr_seen = 1'b1;
    end
    checks++;
    if (clr_seen !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: activity=%b, required 0 with no start", clr_seen);
    end
  endtask

  task automatic test_basic();
    pulse_start(0);
    checks++;
    if ({ora_clr_v[0], we_v[0], busy_v[0]} !== 3'b101) begin
      errors++;
      $display("FAIL basic_load: clr/we/busy=%b, required 101", {ora_clr_v[0], we_v[0], busy_v[0]});
    end
    tick();
    checks++;
    if ({ora_clr_v[0], we_v[0], addr_v[0], data_v[0]} !== {2'b01, 16'h0000, 16'h0001}) begin
      errors++;
      $display("FAIL basic_write0: clr=%b we=%b addr=%h data=%h, required clr=0 we=1 0000/0001",
               ora_clr_v[0], we_v[0], addr_v[0], data_v[0]);
    end
    tick();
    checks++;
    if ({we_v[0], addr_v[0], data_v[0]} !== {1'b1, 16'h0000, 16'h0002}) begin
      errors++;
      $display("FAIL basic_write1: we=%b addr=%h data=%h, required we=1 0000/0002",
               we_v[0], addr_v[0], data_v[0]);
    end
    tick();
    checks++;
    if ({we_v[0], busy_v[0], done_v[0], addr_v[0], data_v[0]} !== {3'b010, 32'h0}) begin
      errors++;
      $display("FAIL basic_check: we=%b busy=%b done=%b addr=%h data=%h, required we=0 busy=1 done=0 bus 0",
               we_v[0], busy_v[0], done_v[0], addr_v[0], data_v[0]);
    end
    tick();
    // Two writes from SEED=1: m=f(0)^1=1, then f(1)^2=0, so the signature is 0 = GOLDEN.
    checks++;
    if ({done_v[0], busy_v[0], pass_v[0], sig_v[0]} !== {3'b101, 32'h0}) begin
      errors++;
      $display("FAIL basic_done: done=%b busy=%b pass=%b sig=%h, required done=1 busy=0 pass=1 sig=0",
               done_v[0], busy_v[0], pass_v[0], sig_v[0]);
    end
    tick();
    checks++;
    if ({done_v[0], pass_v[0], ora_clr_v[0], we_v[0]} !== 4'b1100) begin
      errors++;
      $display("FAIL basic_done_hold: done/pass/clr/we=%b, required 1100",
               {done_v[0], pass_v[0], ora_clr_v[0], we_v[0]});
    end
  endtask

  task automatic test_seed_msb();
    pulse_start(1);
    tick();
    checks++;
    if ({we_v[1], addr_v[1], data_v[1]} !== {1'b1, 16'h8000, 16'h0000}) begin
      errors++;
      $display("FAIL msb_write0: we=%b addr=%h data=%h, required 1 8000/0000", we_v[1], addr_v[1], data_v[1]);
    end
    tick();
    checks++;
    if ({we_v[1], addr_v[1], data_v[1]} !== {1'b1, 16'h0040, 16'h0007}) begin
      errors++;
      $display("FAIL msb_write1: we=%b addr=%h data=%h, required 1 0040/0007", we_v[1], addr_v[1], data_v[1]);
    end
    tick();
    tick();
  endtask

  task automatic test_golden();
    int w;
    bit to;
    pulse_start(2);
    wait_done(2, 400, w, to);
    checks++;
    if (to || w != 256) begin
      errors++;
      $display("FAIL golden_run: timeout=%b writes=%0d, required no timeout and 256", to, w);
    end
    checks++;
    if ({pass_v[2], sig_v[2]} !== {1'b1, GOLD_C}) begin
      errors++;
      $display("FAIL golden_pass: pass=%b sig=%h, required pass=1 sig=%h", pass_v[2], sig_v[2], GOLD_C);
    end
    pulse_start(3);
    wait_done(3, 400, w, to);
    checks++;
    if (to || {done_v[3], pass_v[3], sig_v[3]} !== {2'b10, GOLD_C}) begin
      errors++;
      $display("FAIL golden_mismatch: timeout=%b done=%b pass=%b sig=%h, required done=1 pass=0 sig=%h",
               to, done_v[3], pass_v[3], sig_v[3], GOLD_C);
    end
  endtask

  task automatic test_abort();
    int w;
    bit to;
    pulse_start(2);
    for (int i = 0; i < 6; i++) tick();  // now in RUN cycle 5
    checks++;
    if (we_v[2] !== 1'b1) begin
      errors++;
      $display("FAIL abort_precond: we=%b, required 1 in RUN cycle 5", we_v[2]);
    end
    abort_v[2] = 1'b1;
    tick();
    abort_v[2] = 1'b0;
    checks++;
    if ({we_v[2], busy_v[2], done_v[2], ora_clr_v[2], pass_v[2], sig_v[2]} !== 37'h0) begin
      errors++;
      $display("FAIL abort_idle: we=%b busy=%b done=%b clr=%b pass=%b sig=%h, required all 0",
               we_v[2], busy_v[2], done_v[2], ora_clr_v[2], pass_v[2], sig_v[2]);
    end
    tick();
    pulse_start(2);
    wait_done(2, 400, w, to);
    checks++;
    if (to || w != 256 || {pass_v[2], sig_v[2]} !== {1'b1, GOLD_C}) begin
      errors++;
      $display("FAIL abort_rerun: timeout=%b writes=%0d pass=%b sig=%h, required 256 writes pass=1 sig=%h",
               to, w, pass_v[2], sig_v[2], GOLD_C);
    end
  endtask

  task automatic test_start_during_run();
    int pre;
    int w;
    bit to;
    pre = 0;
    pulse_start(2);
    for (int i = 0; i < 4; i++) begin
      if (we_v[2]) pre++;
      tick();
    end
    start_v[2] = 1'b1;
    if (we_v[2]) pre++;
    tick();
    start_v[2] = 1'b0;
    wait_done(2, 400, w, to);
    checks++;
    if (to || pre + w != 256 || pass_v[2] !== 1'b1) begin
      errors++;
      $display("FAIL start_in_run: timeout=%b writes=%0d pass=%b, required 256 writes pass=1",
               to, pre + w, pass_v[2]);
    end
  endtask

  task automatic test_back_to_back();
    // Instance 0 is sitting in DONE; hold start high to restart.
    start_v[0] = 1'b1;
    tick();
    checks++;
    if ({ora_clr_v[0], done_v[0], busy_v[0]} !== 3'b101) begin
      errors++;
      $display("FAIL restart_load: clr/done/busy=%b, required 101", {ora_clr_v[0], done_v[0], busy_v[0]});
    end
    tick();
    start_v[0] = 1'b0;
    checks++;
    if ({we_v[0], addr_v[0], data_v[0]} !== {1'b1, 16'h0000, 16'h0001}) begin
      errors++;
      $display("FAIL restart_write0: we=%b addr=%h data=%h, required 1 0000/0001", we_v[0], addr_v[0], data_v[0]);
    end
    tick();
    checks++;
    if ({we_v[0], addr_v[0], data_v[0]} !== {1'b1, 16'h0000, 16'h0002}) begin
      errors++;
      $display("FAIL restart_write1: we=%b addr=%h data=%h, required 1 0000/0002", we_v[0], addr_v[0], data_v[0]);
    end
    tick();
    tick();
    checks++;
    if ({done_v[0], pass_v[0]} !== 2'b11) begin
      errors++;
      $display("FAIL restart_done: done=%b pass=%b, required 1 1", done_v[0], pass_v[0]);
    end
  endtask

  task automatic test_abort_start();
    // Instance 1 in DONE: start and abort together -> IDLE.
    start_v[1] = 1'b1;
    abort_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    abort_v[1] = 1'b0;
    checks++;
    if ({ora_clr_v[1], busy_v[1], done_v[1], pass_v[1], we_v[1]} !== 5'b0) begin
      errors++;
      $display("FAIL abort_wins: clr/busy/done/pass/we=%b, required 00000",
               {ora_clr_v[1], busy_v[1], done_v[1], pass_v[1], we_v[1]});
    end
    tick();
    checks++;
    if (ora_clr_v[1] !== 1'b0) begin
      errors++;
      $display("FAIL abort_wins_idle: clr=%b, required 0 (no LOAD)", ora_clr_v[1]);
    end
  endtask

  task automatic test_reset_mid_run();
    pulse_start(2);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({we_v[2], busy_v[2], addr_v[2], data_v[2]} !== 34'h0) begin
      errors++;
      $display("FAIL reset_mid_run: we=%b busy=%b addr=%h data=%h, required all 0 immediately",
               we_v[2], busy_v[2], addr_v[2], data_v[2]);
    end
    tick();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({we_v[2], busy_v[2], done_v[2], sig_v[2]} !== 35'h0) begin
      errors++;
      $display("FAIL reset_stays_idle: we=%b busy=%b done=%b sig=%h, required all 0",
               we_v[2], busy_v[2], done_v[2], sig_v[2]);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_seed_msb();
    test_golden();
    test_abort();
    test_start_during_run();
    test_back_to_back();
    test_abort_start();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
